bla_sub_serial: RTL and testbench
=================================

Name: bla_sub_serial

Overview:
- Multi-cycle WIDTH-bit subtractor computing diff = a - b - b_in.
- Processes one 4-bit nibble per clock, LSB first, through a borrow-lookahead slice: nibble borrows are resolved in parallel and the nibble's borrow-out is registered into the next nibble.
- It is the subtract-direction companion of the team's carry-lookahead add path.
- Used where area matters more than single-cycle latency; valid/ready on both request and result sides.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, number of nibble steps. Derived; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_valid  input  1  request valid.
- start_ready  output  1  high only in IDLE.
- a  input  WIDTH  minuend, sampled on request handshake.
- b  input  WIDTH  subtrahend, sampled on request handshake.
- b_in  input  1  borrow-in, sampled on request handshake.
- done_valid  output  1  result valid, high only in DONE.
- done_ready  input  1  result consumer ready.
- diff  output  WIDTH  result.
- b_out  output  1  final borrow-out (unsigned a < b + b_in).
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; nibble counter=0.
  - Outputs: diff=0, b_out=0, ovf=0, done_valid=0, start_ready=1 from the next cycle.
  - Reset mid-RUN or mid-DONE aborts the operation; the result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start_valid & start_ready:
  - Latch a, b and b_in into operand registers.
  - Counter=0; borrow register=b_in.
- Each RUN cycle operates on the current nibble (a_n, b_n, with bc = borrow register).
  - Per-bit generate and propagate: g = ~a_n & b_n; p = ~(a_n ^ b_n).
  - Borrow chain: w0 = g0 | p0&bc; wi = gi | pi&w(i-1).
  - Nibble difference: d_n = a_n ^ b_n ^ {w2,w1,w0,bc}.
  - d_n shifts into the top of the diff register (the register shifts right by 4).
  - w3 goes to the borrow register; the counter increments.
- RUN -> DONE when the counter reaches NIB-1 (the cycle that processes the last nibble).
  - On that cycle: b_out = w3; ovf = w3 ^ w2 of the MS nibble (borrow into MSB XOR borrow out of MSB).
- Latency: exactly NIB RUN cycles. done_valid rises NIB cycles after the handshake edge (4 for WIDTH=16).
- DONE:
  - done_valid=1; diff, b_out and ovf are stable.
  - Hold until done_ready=1 at a clk edge, then go to IDLE.
  - done_ready asserted before DONE has no effect.
- start_ready=0 in RUN and DONE. start_valid is ignored there; there is no queueing.
- diff, b_out and ovf keep their last values in IDLE until the next completion; they are valid only when done_valid=1.
- Back-to-back: the DONE-accept edge returns to IDLE. The next request is accepted no earlier than the following edge, so minimum throughput is NIB+2 cycles per operation.
- Wrap-around: unsigned results are modulo 2^WIDTH (0 - 1 = all ones with b_out=1).

Optional Feature:
- Macro: BLA_SUB_SAT_EN.
- Defined: signed saturation is applied in the final RUN cycle.
  - If ovf=1 and the sign of a is 0, diff = 0x7FFF (max positive for WIDTH=16).
  - If ovf=1 and the sign of a is 1, diff = 0x8000 (min negative).
  - ovf still reports 1; b_out is unchanged.
- Undefined: diff is the raw wrapped difference; no saturation logic is present.

Test Plan (WIDTH=16):
- Reset, then a=0x1234, b=0x0234, b_in=0 -> 4 RUN cycles, done_valid on the 4th edge after the handshake; diff=0x1000, b_out=0, ovf=0.
- a=0x0000, b=0x0001, b_in=0 -> diff=0xFFFF, b_out=1, ovf=0; a=0x0005, b=0x0003, b_in=1 -> diff=0x0001, b_out=0.
- a=0x8000, b=0x0001 -> ovf=1, b_out=0; diff=0x7FFF without the macro, 0x8000 with BLA_SUB_SAT_EN.
- a=0x7FFF, b=0xFFFF -> ovf=1, b_out=1; diff=0x8000 without the macro, 0x7FFF with BLA_SUB_SAT_EN.
- Hold done_ready=0 for 5 cycles in DONE -> done_valid and diff stay stable, start_ready=0, a second start_valid is ignored; release -> IDLE, start_ready=1 next cycle.
- Assert rst on the 2nd RUN cycle -> next cycle IDLE, done_valid=0, diff=0, b_out=0, ovf=0; a new request then completes correctly.

Source files
------------

// File: rtl/bla_sub_serial.sv
// bla_sub_serial: nibble-serial a - b - b_in through a borrow-lookahead slice.
// Ports: clk, rst, start_valid/start_ready, a, b, b_in, done_valid/done_ready,
// diff, b_out, ovf. Optional signed saturation: define BLA_SUB_SAT_EN.
module bla_sub_serial #(
  parameter int WIDTH = 16,
  localparam int NIB = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out,
  output logic             ovf
);

  localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             bc;
`ifdef BLA_SUB_SAT_EN
  logic             a_sign;
`endif

  logic [3:0]         a_n;
  logic [3:0]         b_n;
  logic [3:0]         g;
  logic [3:0]         p;
  logic [3:0]         w;
  logic [3:0]         d_n;
  logic [WIDTH+3:0]   cat;
  logic [WIDTH-1:0]   diff_nx;
  logic               last;

  assign a_n = a_q[3:0];
  assign b_n = b_q[3:0];
  assign g   = ~a_n & b_n;
  assign p   = ~(a_n ^ b_n);

  // Lookahead: every borrow depends only on g, p and bc.
  assign w[0] = g[0] | (p[0] & bc);
  assign w[1] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & bc);
  assign w[2] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & bc);
  assign w[3] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & bc);

  assign d_n     = a_n ^ b_n ^ {w[2:0], bc};
  assign cat     = {d_n, diff};
  assign diff_nx = cat[WIDTH+3:4];
  assign last    = (cnt == CW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      bc          <= 1'b0;
      diff        <= '0;
      b_out       <= 1'b0;
      ovf         <= 1'b0;
      done_valid  <= 1'b0;
      start_ready <= 1'b1;
`ifdef BLA_SUB_SAT_EN
      a_sign      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            a_q         <= a;
            b_q         <= b;
            bc          <= b_in;
            cnt         <= '0;
            state       <= RUN;
            start_ready <= 1'b0;
`ifdef BLA_SUB_SAT_EN
            a_sign      <= a[WIDTH-1];
`endif
          end
        end
        RUN: begin
          a_q  <= a_q >> 4;
          b_q  <= b_q >> 4;
          bc   <= w[3];
          cnt  <= cnt + 1'b1;
          diff <= diff_nx;
          if (last) begin
            b_out      <= w[3];
            ovf        <= w[3] ^ w[2];
            state      <= DONE;
            done_valid <= 1'b1;
`ifdef BLA_SUB_SAT_EN
            if (w[3] ^ w[2])
              diff <= a_sign
                ? {1'b1, {(WIDTH-1){1'b0}}}
                : {1'b0, {(WIDTH-1){1'b1}}};
`endif
          end
        end
        DONE: begin
          if (done_ready) begin
            state       <= IDLE;
            done_valid  <= 1'b0;
            start_ready <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          done_valid  <= 1'b0;
          start_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bla_sub_serial.sv
// tb_bla_sub_serial: scoreboard bench for bla_sub_serial (WIDTH=16).
// Expected results are queued at the request handshake and popped at accept.
module tb_bla_sub_serial;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         b_in;
  logic         done_valid;
  logic         done_ready;
  logic [W-1:0] diff;
  logic         b_out;
  logic         ovf;

  always #5 clk = ~clk;

  bla_sub_serial #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .a(a),
    .b(b),
    .b_in(b_in),
    .done_valid(done_valid),
    .done_ready(done_ready),
    .diff(diff),
    .b_out(b_out),
    .ovf(ovf)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } res_t;

  res_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] av,
                                 input logic [W-1:0] bv,
                                 input logic bi);
    res_t r;
    logic [W:0] u;
    int s;
    u    = {1'b0, av} - {1'b0, bv} - (W+1)'(bi);
    r.d  = u[W-1:0];
    r.bo = u[W];
    s    = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    r.ov = (s > 32767) || (s < -32768);
`ifdef BLA_SUB_SAT_EN
    if (r.ov) r.d = av[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (!rst && done_valid && done_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("diff", 32'(diff), 32'(e.d));
        chk("b_out", 32'(b_out), 32'(e.bo));
        chk("ovf", 32'(ovf), 32'(e.ov));
      end
    end
  end

  task automatic req(input logic [W-1:0] av,
                     input logic [W-1:0] bv,
                     input logic bi);
    int n;
    @(negedge clk);
    a = av;
    b = bv;
    b_in = bi;
    start_valid = 1'b1;
    n = 0;
    while (!start_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready", 32'(start_ready), 32'd1);
    @(posedge clk);
    sb.push_back(model(av, bv, bi));
    #1 start_valid = 1'b0;
  endtask

  task automatic op(input logic [W-1:0] av,
                    input logic [W-1:0] bv,
                    input logic bi,
                    input int hold);
    int n;
    logic [W-1:0] held;
    req(av, bv, bi);
    n = 0;
    while (!done_valid && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("latency", 32'(n), 32'(NIB));
    held = diff;
    for (int i = 0; i < hold; i++) begin
      start_valid = 1'b1;
      a = ~av;
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(done_valid), 32'd1);
      chk("hold_diff", 32'(diff), 32'(held));
      chk("hold_sready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    done_ready = 1'b1;
    @(posedge clk);
    #1 done_ready = 1'b0;
    chk("acc_sready", 32'(start_ready), 32'd1);
    chk("acc_dvalid", 32'(done_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_valid = 1'b0;
    done_ready = 1'b0;
    a = '0;
    b = '0;
    b_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_sready", 32'(start_ready), 32'd1);
    chk("rst_dvalid", 32'(done_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(b_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    op(16'h1234, 16'h0234, 1'b0, 0);
    op(16'h0000, 16'h0001, 1'b0, 0);
    op(16'h0005, 16'h0003, 1'b1, 0);
    op(16'h8000, 16'h0001, 1'b0, 0);
    op(16'h7FFF, 16'hFFFF, 1'b0, 0);
    op(16'hFFFF, 16'hFFFF, 1'b1, 0);
    op(16'hA5C3, 16'h3C5A, 1'b0, 5);

    // Abort on the second RUN edge; the queued result is dropped.
    req(16'h4321, 16'h1111, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(sb.pop_back());
    chk("abort_sready", 32'(start_ready), 32'd1);
    chk("abort_dvalid", 32'(done_valid), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_bout", 32'(b_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    op(16'h4321, 16'h1111, 1'b0, 0);

    for (int i = 0; i < 12; i++)
      op(W'($urandom), W'($urandom), 1'($urandom), 0);

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
